// File: rtl/qos_mm_regs_if.sv
// Host-side memory-mapped bus of the QoS register block.
// One-cycle read/write strobes, word address, registered read data.
interface qos_mm_regs_if;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;

    modport master (
        output mm_write_en,
        output mm_read_en,
        output mm_addr,
        output mm_wdata,
        input  mm_rdata
    );

    modport slave (
        input  mm_write_en,
        input  mm_read_en,
        input  mm_addr,
        input  mm_wdata,
        output mm_rdata
    );
endinterface

// File: rtl/qos_mm_regs.sv
// QoS controller config/status registers, saturating per-channel
// error counters and the observation-window timer that clears them.
module qos_mm_regs #(
    parameter logic [19:0] RESET_TIMER_DEFAULT = 20'd50_000,
    parameter logic [7:0]  PRIORITY_DEFAULT    = 8'b11_10_01_00
) (
    input  logic                rclk,
    input  logic                rst_n,
    qos_mm_regs_if.slave        mm,
    output logic                fallback_enable,
    output logic                manual_enable,
    output logic [1:0]          manual_channel,
    output logic [7:0]          channel_priority,
    output logic [19:0]         reset_timer,
    output logic                cfg_update,
    input  logic [1:0]          active_channel,
    input  logic [3:0]          signal_present,
    input  logic [3:0]          error_pulse,
    output logic                window_tick
);

    localparam logic [7:0] ADDR_CFG = 8'h00;
    localparam logic [7:0] ADDR_STS = 8'h01;
    localparam logic [7:0] ADDR_ERR = 8'h02;

    localparam logic [31:0] CFG_RESET =
        {RESET_TIMER_DEFAULT, PRIORITY_DEFAULT, 4'b0000};

    logic [31:0]     cfg_q;
    logic [19:0]     timer_q;
    logic [3:0][7:0] err_q;

    logic            wr_cfg;
    logic            wr_err;
    logic            expire;
    logic [3:0]      clr;
    logic [31:0]     rd_val;

    assign fallback_enable  = cfg_q[0];
    assign manual_enable    = cfg_q[1];
    assign manual_channel   = cfg_q[3:2];
    assign channel_priority = cfg_q[11:4];
    assign reset_timer      = cfg_q[31:12];

    // A config write restarts the window, so it also suppresses expiry.
    always_comb begin
        wr_cfg = mm.mm_write_en && (mm.mm_addr == ADDR_CFG);
        wr_err = mm.mm_write_en && (mm.mm_addr == ADDR_ERR);
        expire = !wr_cfg && (reset_timer != 20'd0)
                 && (timer_q == 20'd1);
        for (int n = 0; n < 4; n++) begin
            clr[n] = expire || (wr_err && (|mm.mm_wdata[8*n +: 8]));
        end
    end

    always_comb begin
        rd_val = 32'h0;
        case (mm.mm_addr)
            ADDR_CFG: rd_val = cfg_q;
            ADDR_STS: rd_val = {26'b0, signal_present, active_channel};
            ADDR_ERR: rd_val = err_q;
            default:  rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            cfg_q       <= CFG_RESET;
            cfg_update  <= 1'b0;
            mm.mm_rdata <= 32'h0;
        end else begin
            cfg_update <= wr_cfg;
            if (wr_cfg) begin
                cfg_q <= mm.mm_wdata;
            end
            if (mm.mm_read_en) begin
                mm.mm_rdata <= rd_val;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            timer_q     <= RESET_TIMER_DEFAULT;
            window_tick <= 1'b0;
        end else begin
            window_tick <= expire;
            if (wr_cfg) begin
                timer_q <= mm.mm_wdata[31:12];
            end else if (reset_timer == 20'd0) begin
                timer_q <= 20'd0;
            end else if (timer_q <= 20'd1) begin
                timer_q <= reset_timer;
            end else begin
                timer_q <= timer_q - 20'd1;
            end
        end
    end

    // A pulse landing on a clear is counted, so the lane restarts at 1.
    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (clr[n]) begin
                    err_q[n] <= {7'b0, error_pulse[n]};
                end else if (error_pulse[n] && (err_q[n] != 8'hFF)) begin
                    err_q[n] <= err_q[n] + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/qos_mm_regs.md
# qos_mm_regs

Memory-mapped configuration/status responder for the MPEG-2 TS QoS controller, sitting inside `top_QoS` on the `rclk` domain. It answers `mm_write_en`/`mm_read_en` transactions from the host side, holds the channel-selection configuration driven to the selector/fallback logic, reports the active channel and signal presence, and keeps per-channel saturating error counters. Counters are cleared over a programmable observation window.

## Interface
- `RESET_TIMER_DEFAULT`, 20'd50_000: reset value of `reset_timer` (window length in `rclk` cycles).
- `PRIORITY_DEFAULT`, 8'b11_10_01_00: reset value of `channel_priority`.

- `rclk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mm_write_en`  in  1  write strobe, one cycle per transfer.
- `mm_read_en`  in  1  read strobe, one cycle per transfer.
- `mm_addr`  in  8  word address.
- `mm_wdata`  in  32  write data.
- `mm_rdata`  out  32  registered read data.
- `fallback_enable`  out  1  config bit 0.
- `manual_enable`  out  1  config bit 1.
- `manual_channel`  out  2  config bits [3:2].
- `channel_priority`  out  8  config bits [11:4]; four 2-bit channel IDs, [1:0] highest priority.
- `reset_timer`  out  20  config bits [31:12]; window length.
- `cfg_update`  out  1  one-cycle pulse after each write to 0x00.
- `active_channel`  in  2  channel currently muxed to output.
- `signal_present`  in  4  per-channel presence, bit n = channel n.
- `error_pulse`  in  4  per-channel error event, one-cycle pulses.
- `window_tick`  out  1  one-cycle pulse at each window expiry.

## Operation
- Register map:
  - 0x00 RW: `{reset_timer, channel_priority, manual_channel, manual_enable, fallback_enable}`.
  - 0x01 RO: `{26'b0, signal_present, active_channel}`.
  - 0x02 RO/W1C: `{err3, err2, err1, err0}`, 8 bits each.
  - Any other address reads 32'h0; writes there are ignored.
- Write 0x01: ignored.
- Write 0x02: clears byte lane n to 0 if any bit of `mm_wdata[8n+7:8n]` is 1; other lanes untouched.
- Error counters: increment on `error_pulse[n]`; saturate at 8'hFF (no wrap).
  - Clear coincident with a pulse (W1C or window expiry): counter loads 1, not 0.
- Window timer: 20-bit down-counter.
  - `reset_timer == 0`: timer disabled, held at 0, `window_tick` never asserts.
  - Otherwise counts down from `reset_timer`. On the cycle it equals 1, it asserts `window_tick`, clears all four counters (pulse rule above) and reloads `reset_timer`.
  - Resulting period is exactly `reset_timer` cycles.
  - Any write to 0x00 reloads the timer with the new value on the following edge and restarts the window.

## Timing
- Reset values (edge with `rst_n` low):
  - `mm_rdata` = 0, `cfg_update` = 0, `window_tick` = 0.
  - `fallback_enable` = 0, `manual_enable` = 0, `manual_channel` = 0.
  - `channel_priority` = `PRIORITY_DEFAULT`, `reset_timer` = `RESET_TIMER_DEFAULT`.
  - Counters = 0; timer loaded with `RESET_TIMER_DEFAULT`.
- Reset asserted mid-window or mid-transfer: all state returns to reset values on that edge. A strobe present in the reset cycle is dropped.
- Write: config outputs update on the edge sampling `mm_write_en` = 1 (visible next cycle). `cfg_update` is high for the cycle after that edge.
- Read: `mm_rdata` loads on the edge sampling `mm_read_en` = 1 (1-cycle latency). It holds until the next read or reset.
- Read and write in the same cycle to the same address: the read returns the pre-write value; the write takes effect.
- Status read value is sampled at the read edge; no extra synchronisation (inputs are already on `rclk`).
- `window_tick` and the counter clear occur on the same edge.

## Test plan
- Reset: release `rst_n`, read 0x00, wait 2 cycles → `mm_rdata` = {20'd50000, 8'hE4, 2'b00, 1'b0, 1'b0}. Read 0x02 → 0.
- Config write: write 0x00 = {20'd50000, 8'b11011000, 2'b10, 1, 1} → next cycle `manual_channel` = 2, `channel_priority` = 8'hD8, `cfg_update` pulses once. Readback matches the written value.
- Status: drive `active_channel` = 3, `signal_present` = 4'b1011, read 0x01 → 32'h0000002F. Write 0x01 = 32'hFFFFFFFF, then read 0x01 → unchanged. Read 0x05 → 0.
- Counters: 300 pulses on ch1 and 3 on ch2 → read 0x02 = 32'h0003FF00. Write 0x02 = 32'h0000FF00 → reads 32'h00030000. Pulse on ch2 during a W1C of lane 2 → lane 2 reads 1.
- Window: set `reset_timer` = 20'd10 → `window_tick` every 10 cycles, counters zeroed on each tick. Set `reset_timer` = 0 → no tick over 2000 cycles and counters accumulate.
- Reset mid-window: assert `rst_n` low for one cycle at count 5 → outputs return to reset values and the next tick arrives 50,000 cycles after release.
